uart_packet_framer: RTL and testbench
=====================================

// Module: uart_packet_framer
// PURPOSE
//  Parametrised successor to the byte framer on the UART TX path. Accepts an NBYTES payload
//  plus 4-bit channel ID over valid/ready, and serialises one frame into the UART TX FIFO,
//  byte by byte with full-flag backpressure. Frame = START, HDR{ch,seq}, payload LSB first,
//  optional XOR checksum, END. Sits between the data producers and the UART TX FIFO.
// PARAMETERS
//  NBYTES        4      payload bytes per frame; legal range 1..255
//  START_BYTE    8'hAA  first byte of every frame
//  END_BYTE      8'hBB  last byte of every frame
//  USE_CHECKSUM  1      1: emit CSUM byte before END; 0: omit it
//  USE_SEQ       1      1: HDR[3:0] = running sequence number; 0: HDR[3:0] = 4'h0
// PORTS
//  clk               in   1          system clock; all logic on rising edge
//  rst_n             in   1          reset: one clock, synchronous, active-low
//  data_i            in   8*NBYTES   payload; byte k = data_i[8k+7:8k]
//  ch_i              in   4          channel ID, captured with data_i
//  valid_i           in   1          producer has a frame
//  ready_o           out  1          framer can accept; high only in IDLE
//  uart_fifo_full_i  in   1          UART TX FIFO full
//  uart_data_o       out  8          byte presented to the FIFO
//  uart_wr_en_o      out  1          FIFO write strobe
//  busy_o            out  1          frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (rst_n low at a clk edge): state IDLE, seq 0, byte counter 0, payload and
//    header registers 0, checksum 0. After that edge: ready_o=1, busy_o=0, uart_wr_en_o=0,
//    uart_data_o=8'h00.
//  - Reset mid-frame aborts the frame at that edge. The partial frame is not completed.
//  - Accept: valid_i && ready_o at an edge -> capture data_i, ch_i, and HDR={ch_i, seq or 0};
//    go to WR_START. valid_i must hold until accepted. ready_o is combinational from state.
//  - States: IDLE -> WR_START -> WR_HDR -> WR_BYTES -> [WR_CSUM] -> WR_END -> IDLE.
//  - In every non-IDLE state: uart_wr_en_o = !uart_fifo_full_i. The byte is consumed on
//    edges with uart_wr_en_o=1. State, counter, shift register and checksum advance only
//    on those edges. When full, everything holds and uart_data_o stays stable.
//  - uart_data_o per state:
//      WR_START: START_BYTE
//      WR_HDR:   HDR
//      WR_BYTES: shift reg [7:0], shifted right by 8 per consumed byte
//      WR_CSUM:  checksum
//      WR_END:   END_BYTE
//      IDLE:     8'h00
//  - WR_BYTES leaves after the byte with count == NBYTES-1 is consumed. Counter width is
//    max(1, $clog2(NBYTES)). The counter clears on entry to WR_BYTES.
//  - Checksum = XOR of HDR and all payload bytes. It accumulates as each byte is consumed,
//    so it is valid when WR_CSUM is entered.
//  - seq (4 bit) increments when the END byte is consumed; it wraps 15 -> 0.
//  - Minimum frame time with FIFO never full: NBYTES+3+USE_CHECKSUM writes on consecutive
//    cycles, plus 1 IDLE cycle. Back-to-back frames therefore have a 1-cycle gap.
//  - START/END values inside the payload are not escaped; the receiver relies on the
//    fixed length.
// STRUCTURE
//  - framer_pkg: frame_state_t enum {IDLE, WR_START, WR_HDR, WR_BYTES, WR_CSUM, WR_END},
//    plus FRAME_START_DEF=8'hAA and FRAME_END_DEF=8'hBB. Shared with the RX deframer.
//  - Single module, no sub-modules. The checksum is one XOR accumulator register, inline.
// TESTING
//  1. NBYTES=4, ch_i=3, data_i=32'h44332211, FIFO never full -> bytes
//     AA,30,11,22,33,44,XOR,BB on 8 consecutive cycles, where XOR=8'h30^11^22^33^44=8'h74.
//  2. Same frame, full held high for 3 cycles during byte 22 -> uart_data_o holds 22 and
//     uart_wr_en_o=0 for those cycles. No byte is dropped or duplicated.
//  3. 17 frames back-to-back on ch 1 -> HDR sequence 10..1F, then 10. ready_o is high
//     exactly one cycle between frames.
//  4. rst_n low for one cycle while in WR_BYTES -> next cycle IDLE, ready_o=1,
//     uart_wr_en_o=0, seq=0. The next frame starts with AA,10 for ch 1.
//  5. USE_CHECKSUM=0, NBYTES=1, data 8'hAA -> AA,HDR,AA,BB. The counter does not overrun.
//  6. valid_i asserted while busy_o=1 -> not accepted until IDLE; the data then captured
//     is the value present at the IDLE edge.

Source files
------------

// File: rtl/framer_pkg.sv
// rtl/framer_pkg.sv - shared frame state encoding and default delimiters for UART framer/deframer
//
// Purpose: common definitions for the UART TX packet framer and the RX deframer.
//   frame_state_t   : framer FSM states
//   FRAME_START_DEF : default first byte of every frame
//   FRAME_END_DEF   : default last byte of every frame
package framer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_START = 3'd1,
    WR_HDR   = 3'd2,
    WR_BYTES = 3'd3,
    WR_CSUM  = 3'd4,
    WR_END   = 3'd5
  } frame_state_t;

  localparam logic [7:0] FRAME_START_DEF = 8'hAA;
  localparam logic [7:0] FRAME_END_DEF   = 8'hBB;

endpackage

// File: rtl/uart_packet_framer.sv
// rtl/uart_packet_framer.sv - serialises an NBYTES payload into START,HDR,payload,[CSUM],END bytes
//
// Purpose: accepts one payload + channel ID over valid/ready and writes the
// frame byte by byte into the UART TX FIFO, stalling while the FIFO is full.
// Ports:
//   clk              : system clock, rising edge
//   rst_n            : synchronous active-low reset
//   data_i           : payload, byte k = data_i[8k+7:8k], sent LSB byte first
//   ch_i             : channel ID, captured with data_i into HDR[7:4]
//   valid_i          : producer has a frame (held until accepted)
//   ready_o          : framer idle and able to accept
//   uart_fifo_full_i : UART TX FIFO full
//   uart_data_o      : byte presented to the FIFO
//   uart_wr_en_o     : FIFO write strobe; a byte is consumed on each edge it is high
//   busy_o           : frame in progress
module uart_packet_framer
  import framer_pkg::*;
#(
  parameter int          NBYTES       = 4,
  parameter logic [7:0]  START_BYTE   = FRAME_START_DEF,
  parameter logic [7:0]  END_BYTE     = FRAME_END_DEF,
  parameter int          USE_CHECKSUM = 1,
  parameter int          USE_SEQ      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*NBYTES-1:0]   data_i,
  input  logic [3:0]            ch_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  uart_fifo_full_i,
  output logic [7:0]            uart_data_o,
  output logic                  uart_wr_en_o,
  output logic                  busy_o
);

  localparam int            CW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

  frame_state_t          state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [8*NBYTES-1:0]   shreg_q, shreg_d;
  logic [7:0]            hdr_q, hdr_d;
  logic [7:0]            csum_q, csum_d;
  logic [3:0]            seq_q, seq_d;
  logic                  wr_en;

  assign ready_o      = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  // Every non-idle state has a byte to offer; it is consumed only when the FIFO has room.
  assign wr_en        = busy_o && !uart_fifo_full_i;
  assign uart_wr_en_o = wr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      hdr_q   <= '0;
      csum_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      hdr_q   <= hdr_d;
      csum_q  <= csum_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hdr_d       = hdr_q;
    csum_d      = csum_q;
    seq_d       = seq_q;
    uart_data_o = 8'h00;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = WR_START;
          shreg_d = data_i;
          hdr_d   = {ch_i, (USE_SEQ != 0) ? seq_q : 4'h0};
          csum_d  = 8'h00;
        end
      end

      WR_START: begin
        uart_data_o = START_BYTE;
        if (wr_en) begin
          state_d = WR_HDR;
        end
      end

      WR_HDR: begin
        uart_data_o = hdr_q;
        if (wr_en) begin
          state_d = WR_BYTES;
          cnt_d   = '0;
          csum_d  = csum_q ^ hdr_q;
        end
      end

      WR_BYTES: begin
        uart_data_o = shreg_q[7:0];
        if (wr_en) begin
          csum_d  = csum_q ^ shreg_q[7:0];
          shreg_d = shreg_q >> 8;
          // Counter stops at the last index instead of wrapping, so NBYTES=1 cannot overrun.
          if (cnt_q == CNT_LAST) begin
            state_d = (USE_CHECKSUM != 0) ? WR_CSUM : WR_END;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      WR_CSUM: begin
        uart_data_o = csum_q;
        if (wr_en) begin
          state_d = WR_END;
        end
      end

      WR_END: begin
        uart_data_o = END_BYTE;
        if (wr_en) begin
          state_d = IDLE;
          seq_d   = seq_q + 4'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_packet_framer.sv
// tb/tb_uart_packet_framer.sv - directed self-checking bench for uart_packet_framer
module tb_uart_packet_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // dut0: default parameters (NBYTES=4, checksum on)
  logic [31:0] data0;
  logic [3:0]  ch0;
  logic        valid0, ready0, full0, wr0, busy0;
  logic [7:0]  dout0;

  // dut1: NBYTES=1, no checksum
  logic [7:0]  data1;
  logic [3:0]  ch1;
  logic        valid1, ready1, full1, wr1, busy1;
  logic [7:0]  dout1;

  logic [7:0]  q0[$];
  int          qc0[$];
  logic [7:0]  q1[$];
  int          qc1[$];
  logic [7:0]  exp_q[$];

  uart_packet_framer #(.NBYTES(4), .USE_CHECKSUM(1), .USE_SEQ(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_i(data0), .ch_i(ch0), .valid_i(valid0),
    .ready_o(ready0), .uart_fifo_full_i(full0), .uart_data_o(dout0),
    .uart_wr_en_o(wr0), .busy_o(busy0)
  );

  uart_packet_framer #(.NBYTES(1), .USE_CHECKSUM(0), .USE_SEQ(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_i(data1), .ch_i(ch1), .valid_i(valid1),
    .ready_o(ready1), .uart_fifo_full_i(full1), .uart_data_o(dout1),
    .uart_wr_en_o(wr1), .busy_o(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change #1 after posedge, so the negedge value is what the next edge consumes.
  always @(negedge clk) begin
    if (wr0) begin q0.push_back(dout0); qc0.push_back(cyc); end
    if (wr1) begin q1.push_back(dout1); qc1.push_back(cyc); end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic make_frame(input logic [3:0] ch, input logic [3:0] seq, input logic [31:0] d,
                            input int nb, input bit use_cs);
    logic [7:0] cs, hdr, b;
    hdr = {ch, seq};
    cs  = hdr;
    exp_q.push_back(8'hAA);
    exp_q.push_back(hdr);
    for (int k = 0; k < nb; k++) begin
      b = d[8*k +: 8];
      exp_q.push_back(b);
      cs = cs ^ b;
    end
    if (use_cs) exp_q.push_back(cs);
    exp_q.push_back(8'hBB);
  endtask

  task automatic cmp_frame(input string tag, input int which, input bit consec);
    logic [7:0] got[$];
    int         cy[$];
    int         n;
    if (which == 0) begin got = q0; cy = qc0; q0.delete(); qc0.delete(); end
    else            begin got = q1; cy = qc1; q1.delete(); qc1.delete(); end
    check($sformatf("%s_len", tag), got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
      if (consec) check($sformatf("%s_cyc%0d", tag, i), cy[i] - cy[0], i);
    end
    exp_q.delete();
  endtask

  task automatic send0(input logic [3:0] ch, input logic [31:0] d);
    bit ok = 0;
    ch0 = ch; data0 = d; valid0 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready0) begin ok = 1; break; end
    end
    if (!ok) check("send0_timeout", 0, 1);
    step();
    valid0 = 1'b0;
  endtask

  task automatic wait_idle0(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready0) begin ok = 1; break; end
    end
    if (!ok) check({tag, "_idle_timeout"}, 0, 1);
    step();
  endtask

  task automatic send1(input logic [3:0] ch, input logic [7:0] d);
    bit ok = 0;
    ch1 = ch; data1 = d; valid1 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready1) begin ok = 1; break; end
    end
    if (!ok) check("send1_timeout", 0, 1);
    step();
    valid1 = 1'b0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready1) begin ok = 1; break; end
    end
    if (!ok) check("send1_idle_timeout", 0, 1);
    step();
  endtask

  initial begin
    int accepts, last, gmin, gmax, stall;

    rst_n = 1'b0;
    data0 = '0; ch0 = '0; valid0 = 1'b0; full0 = 1'b0;
    data1 = '0; ch1 = '0; valid1 = 1'b0; full1 = 1'b0;
    step();
    step();

    // Reset state
    @(negedge clk);
    check("rst_ready", ready0, 1);
    check("rst_busy", busy0, 0);
    check("rst_wr_en", wr0, 0);
    check("rst_data", dout0, 8'h00);
    rst_n = 1'b1;
    step();
    q0.delete(); qc0.delete();

    // 1: basic frame, FIFO never full, 8 consecutive writes
    send0(4'd3, 32'h44332211);
    wait_idle0("t1");
    exp_q = '{8'hAA, 8'h30, 8'h11, 8'h22, 8'h33, 8'h44, 8'h74, 8'hBB};
    cmp_frame("t1", 0, 1);

    // 2: FIFO full for 3 cycles while byte 22 is presented
    send0(4'd3, 32'h44332211);
    step(); step(); step();
    full0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t2_hold_data%0d", k), dout0, 8'h22);
      check($sformatf("t2_hold_wr%0d", k), wr0, 0);
      step();
    end
    full0 = 1'b0;
    wait_idle0("t2");
    exp_q = '{8'hAA, 8'h31, 8'h11, 8'h22, 8'h33, 8'h44, 8'h75, 8'hBB};
    cmp_frame("t2", 0, 0);

    // 6: valid held while busy; data present at the IDLE edge is what gets captured
    send0(4'd2, 32'hDEADBEEF);
    ch0 = 4'd5; data0 = 32'h01020304; valid0 = 1'b1;
    stall = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready0) break;
      stall++;
    end
    check("t6_not_ready_cycles", stall, 8);
    data0 = 32'hCAFEF00D;
    step();
    valid0 = 1'b0;
    wait_idle0("t6");
    make_frame(4'd2, 4'd2, 32'hDEADBEEF, 4, 1);
    make_frame(4'd5, 4'd3, 32'hCAFEF00D, 4, 1);
    cmp_frame("t6", 0, 0);

    // 4: reset while in WR_BYTES aborts the frame and clears seq
    send0(4'd1, 32'h11223344);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("t4_ready", ready0, 1);
    check("t4_busy", busy0, 0);
    check("t4_wr_en", wr0, 0);
    check("t4_data", dout0, 8'h00);
    rst_n = 1'b1;
    step();
    q0.delete(); qc0.delete();
    send0(4'd1, 32'h55667788);
    wait_idle0("t4");
    make_frame(4'd1, 4'd0, 32'h55667788, 4, 1);
    cmp_frame("t4", 0, 1);

    // 3: 17 back-to-back frames on ch 1 starting from seq 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    q0.delete(); qc0.delete();
    ch0 = 4'd1; data0 = 32'h0A0B0C0D; valid0 = 1'b1;
    accepts = 0; last = -1; gmin = 1000; gmax = 0;
    for (int i = 0; i < 400 && accepts < 17; i++) begin
      @(negedge clk);
      if (ready0) begin
        accepts++;
        if (last >= 0) begin
          if (cyc - last < gmin) gmin = cyc - last;
          if (cyc - last > gmax) gmax = cyc - last;
        end
        last = cyc;
      end
      step();
    end
    valid0 = 1'b0;
    check("t3_accepts", accepts, 17);
    check("t3_gap_min", gmin, 9);
    check("t3_gap_max", gmax, 9);
    wait_idle0("t3");
    for (int i = 0; i < 17; i++) make_frame(4'd1, 4'(i), 32'h0A0B0C0D, 4, 1);
    cmp_frame("t3", 0, 0);

    // 5: NBYTES=1, no checksum, payload equal to START
    q1.delete(); qc1.delete();
    send1(4'd7, 8'hAA);
    exp_q = '{8'hAA, 8'h70, 8'hAA, 8'hBB};
    cmp_frame("t5a", 1, 1);
    send1(4'd7, 8'h5C);
    make_frame(4'd7, 4'd1, 32'h0000005C, 1, 0);
    cmp_frame("t5b", 1, 1);
    @(negedge clk);
    check("t5_busy_after", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
